// File: rtl/siso_pkg.sv
// Shared constants for the siso_chain data path: PRBS8 polynomial/seed,
// counter width and legal parameter ranges.
package siso_pkg;
  localparam int              PRBS_W     = 8;
  localparam logic [PRBS_W-1:0] PRBS_TAPS = 8'hB8;  // x^8+x^6+x^5+x^4+1 on s[7:0]
  localparam logic [PRBS_W-1:0] PRBS_SEED = 8'h01;
  localparam int              CNT_W      = 8;
  localparam int              DEPTH_MIN  = 2;
  localparam int              DEPTH_MAX  = 256;
  localparam int              JW_MIN     = 2;
  localparam int              JW_MAX     = 8;

  function automatic logic prbs_fb(input logic [PRBS_W-1:0] s);
    return ^(s & PRBS_TAPS);
  endfunction
endpackage

// File: rtl/siso_chain_if.sv
// Control/data bundle between siso_chain and its driver.
interface siso_chain_if #(parameter int JW = 4);
  logic                        en;
  logic                        din_sel;
  logic                        d_in;
  logic                        inj;
  logic                        d_out;
  logic                        valid;
  logic [JW-1:0]               johnson;
  logic [2*JW-1:0]             pulses;
  logic                        prbs_bit;
  logic                        prbs_period;
  logic                        err;
  logic [siso_pkg::CNT_W-1:0]  err_count;

  modport master (output en, din_sel, d_in, inj,
                  input  d_out, valid, johnson, pulses, prbs_bit, prbs_period, err, err_count);
  modport slave  (input  en, din_sel, d_in, inj,
                  output d_out, valid, johnson, pulses, prbs_bit, prbs_period, err, err_count);
endinterface

// File: rtl/siso_chain_prbs8_gen.sv
// PRBS8 generator (period 255): output bit is state[7], period marker at the seed.
module prbs8_gen
  import siso_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic prbs_bit,
  output logic prbs_period
);
  logic [PRBS_W-1:0] state;

  always_ff @(posedge clk) begin
    if (rst)     state <= PRBS_SEED;
    else if (en) state <= {state[PRBS_W-2:0], prbs_fb(state)};
  end

  assign prbs_bit    = state[PRBS_W-1];
  assign prbs_period = (state == PRBS_SEED);
endmodule

// File: rtl/siso_chain.sv
// Serial delay chain with Johnson phase counter/decode and PRBS8 source.
// Optional PRBS self-checker on the chain output: define SISO_PRBS_CHECK_EN.
module siso_chain
  import siso_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int JW    = 4
) (
  input  logic        clk,
  input  logic        rst,
  siso_chain_if.slave bus
);
  localparam int FILL_W = $clog2(DEPTH + 1);
  localparam int NJ     = 2 * JW;
  localparam int IDX_W  = $clog2(NJ);

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX || JW < JW_MIN || JW > JW_MAX) begin : g_bad_param
    $error("siso_chain: DEPTH or JW out of range");
  end

  logic [DEPTH-1:0]  chain;
  logic [FILL_W-1:0] fill;
  logic [JW-1:0]     john, john_nxt, jst;
  logic [IDX_W-1:0]  jidx;
  logic              jlegal;
  logic [NJ-1:0]     pulses;
  logic              bit_in, prbs_bit, prbs_period;

  prbs8_gen u_prbs (
    .clk         (clk),
    .rst         (rst),
    .en          (bus.en),
    .prbs_bit    (prbs_bit),
    .prbs_period (prbs_period)
  );

  assign bit_in = (bus.din_sel ? prbs_bit : bus.d_in) ^ bus.inj;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      fill  <= '0;
      john  <= '0;
    end else if (bus.en) begin
      chain <= {chain[DEPTH-2:0], bit_in};
      if (fill != FILL_W'(DEPTH)) fill <= fill + 1'b1;
      john  <= john_nxt;
    end
  end

  // Walk the legal Johnson sequence to find the state index; anything off it recovers to 0.
  always_comb begin
    jst    = '0;
    jidx   = '0;
    jlegal = 1'b0;
    for (int k = 0; k < NJ; k++) begin
      if (john == jst) begin
        jlegal = 1'b1;
        jidx   = IDX_W'(k);
      end
      jst = {jst[JW-2:0], ~jst[JW-1]};
    end
    john_nxt = jlegal ? {john[JW-2:0], ~john[JW-1]} : '0;
    pulses   = jlegal ? ({{(NJ-1){1'b0}}, 1'b1} << jidx) : '0;
  end

  assign bus.d_out       = chain[DEPTH-1];
  assign bus.valid       = (fill == FILL_W'(DEPTH));
  assign bus.johnson     = john;
  assign bus.pulses      = pulses;
  assign bus.prbs_bit    = prbs_bit;
  assign bus.prbs_period = prbs_period;

`ifdef SISO_PRBS_CHECK_EN
  localparam int ARM_MAX = DEPTH + 8;
  localparam int ARM_W   = $clog2(ARM_MAX + 1);

  logic [PRBS_W-1:0] hist;
  logic [ARM_W-1:0]  arm;
  logic              err_q, mism;
  logic [CNT_W-1:0]  err_cnt;

  // Armed only once the chain and history hold nothing but generator bits.
  assign mism = (arm == ARM_W'(ARM_MAX)) && (chain[DEPTH-2] != prbs_fb(hist));

  always_ff @(posedge clk) begin
    if (rst) begin
      hist    <= '0;
      arm     <= '0;
      err_q   <= 1'b0;
      err_cnt <= '0;
    end else begin
      err_q <= 1'b0;
      if (bus.en) begin
        hist <= {hist[PRBS_W-2:0], chain[DEPTH-2]};
        if (!bus.din_sel)                 arm <= '0;
        else if (arm != ARM_W'(ARM_MAX)) arm <= arm + 1'b1;
        if (mism) begin
          err_q <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.err       = err_q;
  assign bus.err_count = err_cnt;
`else
  assign bus.err       = 1'b0;
  assign bus.err_count = '0;
`endif
endmodule

// File: tb/tb_siso_chain.sv
// Scoreboard bench for siso_chain (DEPTH=8, JW=4); checker tests under SISO_PRBS_CHECK_EN.
module tb_siso_chain;
  localparam int DEPTH = 8;
  localparam int JW    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  siso_chain_if #(.JW(JW)) bus ();

  siso_chain #(.DEPTH(DEPTH), .JW(JW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  bit         sb_q[$];
  int         en_cnt;
  logic [7:0] ps;
  logic [3:0] jtab [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                           4'b1111, 4'b1110, 4'b1100, 4'b1000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset(input bit en_v);
    rst         = 1'b1;
    bus.en      = en_v;
    bus.d_in    = 1'b1;
    bus.din_sel = 1'b0;
    bus.inj     = 1'b0;
    @(posedge clk); #1;
    rst    = 1'b0;
    bus.en = 1'b0;
    sb_q.delete();
    ps     = 8'h01;
    en_cnt = 0;
    chk("rst_d_out",   bus.d_out,       0);
    chk("rst_valid",   bus.valid,       0);
    chk("rst_johnson", bus.johnson,     0);
    chk("rst_pulses",  bus.pulses,      8'b0000_0001);
    chk("rst_period",  bus.prbs_period, 1);
    chk("rst_err",     bus.err,         0);
    chk("rst_err_cnt", bus.err_count,   0);
  endtask

  // One enabled edge: push the bit entering stage 0, pop the bit due at D_OUT.
  task automatic step(input bit sel, input bit din, input bit inj);
    bit b, e;
    b = (sel ? ps[7] : din) ^ inj;
    bus.en = 1'b1; bus.din_sel = sel; bus.d_in = din; bus.inj = inj;
    @(posedge clk); #1;
    bus.en = 1'b0; bus.inj = 1'b0;
    sb_q.push_back(b);
    ps = {ps[6:0], ps[7] ^ ps[5] ^ ps[4] ^ ps[3]};
    en_cnt++;
    e = (sb_q.size() == DEPTH) ? sb_q.pop_front() : 1'b0;
    chk("d_out",    bus.d_out,       e);
    chk("valid",    bus.valid,       en_cnt >= DEPTH);
    chk("johnson",  bus.johnson,     jtab[en_cnt % 8]);
    chk("pulses",   bus.pulses,      32'd1 << (en_cnt % 8));
    chk("prbs_bit", bus.prbs_bit,    ps[7]);
    chk("period",   bus.prbs_period, ps == 8'h01);
`ifndef SISO_PRBS_CHECK_EN
    chk("err_off",     bus.err,       0);
    chk("err_cnt_off", bus.err_count, 0);
`endif
  endtask

  task automatic idle(input int n);
    logic       d0;
    logic [3:0] j0;
    d0 = bus.d_out; j0 = bus.johnson;
    bus.en = 1'b0; bus.d_in = 1'b1; bus.din_sel = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      chk("hold_d_out",   bus.d_out,   d0);
      chk("hold_johnson", bus.johnson, j0);
      chk("hold_err",     bus.err,     0);
    end
  endtask

  task automatic impulse_test();
    for (int k = 1; k <= 10; k++) begin
      step(1'b0, k == 1, 1'b0);
      chk("imp_d_out", bus.d_out, k == DEPTH);
      chk("imp_valid", bus.valid, k >= DEPTH);
    end
  endtask

  initial begin
    int pcnt;
    bus.en = 1'b0; bus.din_sel = 1'b0; bus.d_in = 1'b0; bus.inj = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;

    do_reset(1'b0);
    impulse_test();

    // Johnson walk with frozen gaps
    do_reset(1'b0);
    for (int k = 1; k <= 9; k++) begin
      step(1'b0, 1'b0, 1'b0);
      if (k % 3 == 0) idle(2);
    end
    chk("john_wrap", bus.johnson, 4'b0001);

    // mixed random traffic
    for (int k = 0; k < 60; k++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
      if ($urandom_range(0, 4) == 0) idle(1);
    end

    // PRBS period
    do_reset(1'b0);
    pcnt = 0;
    for (int k = 0; k < 255; k++) begin
      step(1'b1, 1'b0, 1'b0);
      if (bus.prbs_period) pcnt++;
    end
    chk("period_count", pcnt, 1);
    chk("period_end",   bus.prbs_period, 1);

`ifdef SISO_PRBS_CHECK_EN
    do_reset(1'b0);
    for (int k = 0; k < 1000; k++) step(1'b1, 1'b0, 1'b0);
    chk("chk_clean", bus.err_count, 0);
    step(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 30; k++) step(1'b1, 1'b0, 1'b0);
    chk("chk_inject", bus.err_count, 5);
`endif

    // mid-run reset with EN held high, then latency again
    for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b0);
    do_reset(1'b1);
    impulse_test();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
